// File: rtl/ahb2obi_slave_adapter.sv
// AHB-Lite slave that forwards each accepted transfer as a single OBI transaction
// and returns the OBI response as the AHB data-phase completion (one outstanding).
module ahb2obi_slave_adapter #(
    parameter int unsigned ADDR_WIDTH      = 32,
    parameter bit          ERR_ON_MISALIGN = 1'b1
) (
    input  logic                  hclk_i,
    input  logic                  hreset_i,
    input  logic                  hsel_i,
    input  logic [ADDR_WIDTH-1:0] haddr_i,
    input  logic [1:0]            htrans_i,
    input  logic                  hwrite_i,
    input  logic [2:0]            hsize_i,
    input  logic [31:0]           hwdata_i,
    input  logic                  hready_i,
    output logic [31:0]           hrdata_o,
    output logic                  hreadyout_o,
    output logic                  hresp_o,
    output logic                  obi_req_o,
    input  logic                  obi_gnt_i,
    output logic [ADDR_WIDTH-1:0] obi_addr_o,
    output logic                  obi_we_o,
    output logic [3:0]            obi_be_o,
    output logic [31:0]           obi_wdata_o,
    input  logic                  obi_rvalid_i,
    input  logic [31:0]           obi_rdata_i,
    input  logic                  obi_err_i
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_REQ  = 3'd1,
        ST_RESP = 3'd2,
        ST_ERR1 = 3'd3,
        ST_ERR2 = 3'd4
    } state_e;

    state_e                state_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  we_q;
    logic [3:0]            be_q;
    logic [31:0]           hrdata_q;

    logic                  accept_s;
    logic                  illegal_s;
    logic                  complete_s;
    logic [ADDR_WIDTH-1:0] addr_d;
    logic [3:0]            be_d;

    // Byte lanes depend only on the address bits a lane-aligned transfer may use,
    // so a misaligned transfer in non-erroring mode is implicitly aligned down.
    function automatic logic [3:0] calc_be(input logic [2:0] size, input logic [1:0] a);
        logic [3:0] be;
        case (size)
            3'd0:    be = 4'b0001 << a;
            3'd1:    be = 4'b0011 << {a[1], 1'b0};
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    function automatic logic is_illegal(input logic [2:0] size, input logic [1:0] a);
        logic bad;
        case (size)
            3'd0:    bad = 1'b0;
            3'd1:    bad = a[0];
            3'd2:    bad = (a != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

    assign accept_s   = hsel_i & hready_i & ((htrans_i == 2'b10) | (htrans_i == 2'b11));
    assign illegal_s  = ERR_ON_MISALIGN & is_illegal(hsize_i, haddr_i[1:0]);
    assign addr_d     = {haddr_i[ADDR_WIDTH-1:2], 2'b00};
    assign be_d       = calc_be(hsize_i, haddr_i[1:0]);
    assign complete_s = (state_q == ST_RESP) & obi_rvalid_i & ~obi_err_i;

    assign obi_req_o   = (state_q == ST_REQ);
    assign obi_addr_o  = addr_q;
    assign obi_we_o    = we_q;
    assign obi_be_o    = be_q;
    assign obi_wdata_o = (state_q == ST_REQ) ? hwdata_i : 32'h0000_0000;
    assign hresp_o     = (state_q == ST_ERR1) | (state_q == ST_ERR2);
    assign hreadyout_o = (state_q == ST_IDLE) | (state_q == ST_ERR2) | complete_s;
    // Read data is passed through in the completion cycle so no extra wait state is needed.
    assign hrdata_o    = complete_s ? obi_rdata_i : hrdata_q;

    // Transfer FSM together with the captured address-phase fields and read data.
    always_ff @(posedge hclk_i or posedge hreset_i) begin
        if (hreset_i) begin
            state_q  <= ST_IDLE;
            addr_q   <= '0;
            we_q     <= 1'b0;
            be_q     <= 4'b0000;
            hrdata_q <= 32'h0000_0000;
        end else begin
            case (state_q)
                ST_IDLE, ST_ERR2: begin
                    if (accept_s) begin
                        addr_q  <= addr_d;
                        we_q    <= hwrite_i;
                        be_q    <= be_d;
                        state_q <= illegal_s ? ST_ERR1 : ST_REQ;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_REQ: begin
                    if (obi_gnt_i) begin
                        state_q <= ST_RESP;
                    end else begin
                        state_q <= ST_REQ;
                    end
                end
                ST_RESP: begin
                    if (obi_rvalid_i && obi_err_i) begin
                        state_q <= ST_ERR1;
                    end else if (obi_rvalid_i) begin
                        hrdata_q <= obi_rdata_i;
                        // The completion cycle doubles as the next address phase.
                        if (accept_s) begin
                            addr_q  <= addr_d;
                            we_q    <= hwrite_i;
                            be_q    <= be_d;
                            state_q <= illegal_s ? ST_ERR1 : ST_REQ;
                        end else begin
                            state_q <= ST_IDLE;
                        end
                    end else begin
                        state_q <= ST_RESP;
                    end
                end
                ST_ERR1: begin
                    state_q <= ST_ERR2;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ahb2obi_slave_adapter.sv
// Directed bench for ahb2obi_slave_adapter: one task per scenario, inline checks.
module tb_ahb2obi_slave_adapter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        hsel = 1'b0;
    logic [31:0] haddr = 32'h0;
    logic [1:0]  htrans = 2'b00;
    logic        hwrite = 1'b0;
    logic [2:0]  hsize = 3'd0;
    logic [31:0] hwdata = 32'h0;
    logic        hready;
    logic [31:0] hrdata;
    logic        hreadyout;
    logic        hresp;
    logic        req;
    logic        gnt = 1'b0;
    logic [31:0] oaddr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        rvalid = 1'b0;
    logic [31:0] rdata = 32'h0;
    logic        err = 1'b0;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    // Single slave on the bus: bus-level HREADY follows this slave.
    assign hready = hreadyout;

    ahb2obi_slave_adapter #(.ADDR_WIDTH(32), .ERR_ON_MISALIGN(1'b1)) dut (
        .hclk_i(clk), .hreset_i(rst), .hsel_i(hsel), .haddr_i(haddr),
        .htrans_i(htrans), .hwrite_i(hwrite), .hsize_i(hsize), .hwdata_i(hwdata),
        .hready_i(hready), .hrdata_o(hrdata), .hreadyout_o(hreadyout), .hresp_o(hresp),
        .obi_req_o(req), .obi_gnt_i(gnt), .obi_addr_o(oaddr), .obi_we_o(we),
        .obi_be_o(be), .obi_wdata_o(wdata), .obi_rvalid_i(rvalid),
        .obi_rdata_i(rdata), .obi_err_i(err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic addr_phase(input logic [31:0] a, input logic w, input logic [2:0] s);
        hsel = 1'b1; haddr = a; htrans = 2'b10; hwrite = w; hsize = s;
    endtask

    task automatic bus_idle();
        hsel = 1'b0; htrans = 2'b00;
    endtask

    task automatic test_reset();
        #3;
        checks++; if (hreadyout !== 1'b1) begin failures++; $display("FAIL reset_hreadyout got=%b exp=1", hreadyout); end
        checks++; if (hresp !== 1'b0) begin failures++; $display("FAIL reset_hresp got=%b exp=0", hresp); end
        checks++; if (req !== 1'b0) begin failures++; $display("FAIL reset_req got=%b exp=0", req); end
        checks++; if ({we, be} !== 5'b0) begin failures++; $display("FAIL reset_we_be got=%b exp=00000", {we, be}); end
        checks++; if (oaddr !== 32'h0) begin failures++; $display("FAIL reset_addr got=%h exp=0", oaddr); end
        checks++; if (hrdata !== 32'h0) begin failures++; $display("FAIL reset_hrdata got=%h exp=0", hrdata); end
        tick();
        rst = 1'b0;
    endtask

    task automatic test_word_read(input logic [31:0] a, input logic [31:0] d);
        tick();
        addr_phase(a, 1'b0, 3'd2); gnt = 1'b1;
        tick();
        bus_idle(); #1;
        checks++; if (req !== 1'b1 || hreadyout !== 1'b0) begin failures++; $display("FAIL rd_req got req=%b rdy=%b exp req=1 rdy=0", req, hreadyout); end
        checks++; if (oaddr !== a || be !== 4'b1111 || we !== 1'b0) begin failures++; $display("FAIL rd_fields got addr=%h be=%b we=%b exp addr=%h be=1111 we=0", oaddr, be, we, a); end
        tick();
        gnt = 1'b0; rvalid = 1'b1; rdata = d; #1;
        checks++; if (hreadyout !== 1'b1 || hresp !== 1'b0 || req !== 1'b0) begin failures++; $display("FAIL rd_done got rdy=%b resp=%b req=%b exp 1 0 0", hreadyout, hresp, req); end
        checks++; if (hrdata !== d) begin failures++; $display("FAIL rd_data got=%h exp=%h", hrdata, d); end
        tick();
        rvalid = 1'b0; rdata = 32'h0; #1;
        checks++; if (hrdata !== d || hreadyout !== 1'b1) begin failures++; $display("FAIL rd_hold got data=%h rdy=%b exp data=%h rdy=1", hrdata, hreadyout, d); end
    endtask

    task automatic test_byte_write();
        int waits;
        waits = 0;
        tick();
        addr_phase(32'h0000_0003, 1'b1, 3'd0);
        tick();
        bus_idle(); hwdata = 32'hAA00_0000;
        for (int i = 0; i < 4; i++) begin
            gnt = (i == 3); #1;
            if (hreadyout === 1'b0) waits++;
            checks++; if (req !== 1'b1 || be !== 4'b1000 || wdata !== 32'hAA00_0000 || oaddr !== 32'h0 || we !== 1'b1) begin
                failures++; $display("FAIL wr_hold cyc=%0d got req=%b be=%b wdata=%h addr=%h we=%b exp 1 1000 aa000000 0 1", i, req, be, wdata, oaddr, we);
            end
            tick();
        end
        gnt = 1'b0; rvalid = 1'b1; #1;
        checks++; if (hreadyout !== 1'b1 || hresp !== 1'b0 || req !== 1'b0) begin failures++; $display("FAIL wr_done got rdy=%b resp=%b req=%b exp 1 0 0", hreadyout, hresp, req); end
        checks++; if (waits !== 4) begin failures++; $display("FAIL wr_waits got=%0d exp=4", waits); end
        checks++; if (wdata !== 32'h0) begin failures++; $display("FAIL wr_wdata_idle got=%h exp=0", wdata); end
        tick();
        rvalid = 1'b0;
    endtask

    task automatic test_misalign();
        tick();
        addr_phase(32'h0000_0001, 1'b0, 3'd1);
        tick();
        bus_idle(); #1;
        checks++; if (req !== 1'b0 || hresp !== 1'b1 || hreadyout !== 1'b0) begin failures++; $display("FAIL mis_err1 got req=%b resp=%b rdy=%b exp 0 1 0", req, hresp, hreadyout); end
        tick();
        checks++; if (req !== 1'b0 || hresp !== 1'b1 || hreadyout !== 1'b1) begin failures++; $display("FAIL mis_err2 got req=%b resp=%b rdy=%b exp 0 1 1", req, hresp, hreadyout); end
        tick();
        checks++; if (req !== 1'b0 || hresp !== 1'b0 || hreadyout !== 1'b1) begin failures++; $display("FAIL mis_idle got req=%b resp=%b rdy=%b exp 0 0 1", req, hresp, hreadyout); end
    endtask

    task automatic test_obi_error();
        tick();
        addr_phase(32'h0000_0040, 1'b1, 3'd2);
        tick();
        bus_idle(); hwdata = 32'h1234_5678; gnt = 1'b1; #1;
        checks++; if (req !== 1'b1 || we !== 1'b1 || oaddr !== 32'h40) begin failures++; $display("FAIL oe_req got req=%b we=%b addr=%h exp 1 1 40", req, we, oaddr); end
        tick();
        gnt = 1'b0; rvalid = 1'b1; err = 1'b1; #1;
        checks++; if (hreadyout !== 1'b0 || hresp !== 1'b0) begin failures++; $display("FAIL oe_resp got rdy=%b resp=%b exp 0 0", hreadyout, hresp); end
        tick();
        rvalid = 1'b0; err = 1'b0; #1;
        checks++; if (hresp !== 1'b1 || hreadyout !== 1'b0) begin failures++; $display("FAIL oe_err1 got resp=%b rdy=%b exp 1 0", hresp, hreadyout); end
        tick();
        addr_phase(32'h0000_0044, 1'b0, 3'd2); #1;
        checks++; if (hresp !== 1'b1 || hreadyout !== 1'b1) begin failures++; $display("FAIL oe_err2 got resp=%b rdy=%b exp 1 1", hresp, hreadyout); end
        tick();
        bus_idle(); gnt = 1'b1; #1;
        checks++; if (req !== 1'b1 || oaddr !== 32'h44 || we !== 1'b0) begin failures++; $display("FAIL oe_next_req got req=%b addr=%h we=%b exp 1 44 0", req, oaddr, we); end
        tick();
        gnt = 1'b0; rvalid = 1'b1; rdata = 32'h0BAD_F00D; #1;
        checks++; if (hreadyout !== 1'b1 || hresp !== 1'b0 || hrdata !== 32'h0BAD_F00D) begin failures++; $display("FAIL oe_next_done got rdy=%b resp=%b data=%h exp 1 0 0badf00d", hreadyout, hresp, hrdata); end
        tick();
        rvalid = 1'b0;
    endtask

    task automatic test_back_to_back();
        tick();
        addr_phase(32'h0000_0020, 1'b0, 3'd2);
        tick();
        bus_idle(); gnt = 1'b1; #1;
        checks++; if (req !== 1'b1 || oaddr !== 32'h20 || we !== 1'b0) begin failures++; $display("FAIL b2b_req1 got req=%b addr=%h we=%b exp 1 20 0", req, oaddr, we); end
        tick();
        gnt = 1'b0; rvalid = 1'b1; rdata = 32'h1111_2222;
        addr_phase(32'h0000_0024, 1'b1, 3'd2); #1;
        checks++; if (hreadyout !== 1'b1 || hrdata !== 32'h1111_2222) begin failures++; $display("FAIL b2b_done1 got rdy=%b data=%h exp 1 11112222", hreadyout, hrdata); end
        tick();
        bus_idle(); rvalid = 1'b0; hwdata = 32'h3333_4444; gnt = 1'b1; #1;
        checks++; if (req !== 1'b1 || oaddr !== 32'h24 || we !== 1'b1 || wdata !== 32'h3333_4444 || hreadyout !== 1'b0) begin
            failures++; $display("FAIL b2b_req2 got req=%b addr=%h we=%b wdata=%h rdy=%b exp 1 24 1 33334444 0", req, oaddr, we, wdata, hreadyout);
        end
        tick();
        gnt = 1'b0; rvalid = 1'b1; #1;
        checks++; if (hreadyout !== 1'b1 || hresp !== 1'b0) begin failures++; $display("FAIL b2b_done2 got rdy=%b resp=%b exp 1 0", hreadyout, hresp); end
        tick();
        rvalid = 1'b0;
    endtask

    task automatic test_reset_mid();
        tick();
        addr_phase(32'h0000_0030, 1'b0, 3'd2);
        tick();
        bus_idle(); gnt = 1'b1;
        tick();
        gnt = 1'b0; #1;
        checks++; if (hreadyout !== 1'b0 || req !== 1'b0) begin failures++; $display("FAIL rm_resp got rdy=%b req=%b exp 0 0", hreadyout, req); end
        rst = 1'b1; #1;
        checks++; if (hreadyout !== 1'b1 || req !== 1'b0 || hresp !== 1'b0 || hrdata !== 32'h0) begin
            failures++; $display("FAIL rm_async got rdy=%b req=%b resp=%b data=%h exp 1 0 0 0", hreadyout, req, hresp, hrdata);
        end
        tick();
        rst = 1'b0;
        test_word_read(32'h0000_0050, 32'hCAFE_F00D);
    endtask

    initial begin
        test_reset();
        test_word_read(32'h0000_0010, 32'hDEAD_BEEF);
        test_byte_write();
        test_misalign();
        test_obi_error();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
